// File: rtl/emulib_ready_valid_eager_fork_if.sv
// Handshake bundle for the eager fork: one upstream ready/valid port fanned out to
// BRANCHES downstream ready/valid ports sharing a single payload.
interface emulib_ready_valid_eager_fork_if #(
    parameter int BRANCHES   = 2,
    parameter int DATA_WIDTH = 32
);
    logic                  i_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] i_data;
    logic [BRANCHES-1:0]   i_mask;
    logic [BRANCHES-1:0]   o_valid;
    logic [BRANCHES-1:0]   o_ready;
    logic [DATA_WIDTH-1:0] o_data;

    // The fork itself: consumes upstream valid/payload and branch readies.
    modport master (
        input  i_valid, i_data, i_mask, o_ready,
        output i_ready, o_valid, o_data
    );

    // The environment around the fork: upstream producer plus branch consumers.
    modport slave (
        output i_valid, i_data, i_mask, o_ready,
        input  i_ready, o_valid, o_data
    );
endinterface

// File: rtl/emulib_ready_valid_eager_fork.sv
// Eager ready/valid fork: each selected branch is offered the upstream transfer
// independently and the upstream is released once every selected branch has taken it.
module emulib_ready_valid_eager_fork #(
    parameter int BRANCHES   = 2,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    emulib_ready_valid_eager_fork_if.master bus,
    output logic                 o_busy,
    output logic [CNT_WIDTH-1:0] o_count
);

    logic [BRANCHES-1:0] done;
    logic [BRANCHES-1:0] valid_out;
    logic [BRANCHES-1:0] handshake;
    logic [BRANCHES-1:0] complete;
    logic                accept;

    // o_valid never looks at o_ready, so no ready-to-valid combinational path exists.
    assign valid_out = {BRANCHES{bus.i_valid}} & bus.i_mask & ~done;
    assign handshake = valid_out & bus.o_ready;
    assign complete  = done | ~bus.i_mask | handshake;
    assign accept    = bus.i_valid & bus.i_ready;

    assign bus.o_valid = valid_out;
    assign bus.i_ready = &complete;
    assign bus.o_data  = bus.i_data;
    assign o_busy      = |done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done    <= '0;
            o_count <= '0;
        end else if (accept) begin
            done    <= '0;
            o_count <= o_count + CNT_WIDTH'(1);
        end else begin
            // Remember branches that took the payload so they are not offered it twice.
            done <= done | handshake;
        end
    end

endmodule

// File: doc/emulib_ready_valid_eager_fork.md
EMULIB_READY_VALID_EAGER_FORK -- requirements
Module: emulib_ready_valid_eager_fork

Interface
REQ-001 Parameter BRANCHES, default 2: number of output branches; legal range 1..32.
REQ-002 Parameter DATA_WIDTH, default 32: payload width; legal range 1..1024.
REQ-003 Parameter CNT_WIDTH, default 16: transfer counter width; legal range 1..32.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rstn  input  1  reset; asynchronous assert, active-low.
REQ-006 i_valid  input  1  upstream transfer valid.
REQ-007 i_ready  output  1  upstream transfer accepted this cycle when high together with i_valid.
REQ-008 i_data  input  DATA_WIDTH  upstream payload.
REQ-009 i_mask  input  BRANCHES  per-transfer branch select; bit b high = branch b receives the transfer.
REQ-010 o_valid  output  BRANCHES  per-branch valid.
REQ-011 o_ready  input  BRANCHES  per-branch ready.
REQ-012 o_data  output  DATA_WIDTH  payload broadcast to all branches; equals i_data combinationally.
REQ-013 o_busy  output  1  high when at least one branch of the current transfer has already completed.
REQ-014 o_count  output  CNT_WIDTH  number of upstream transfers accepted since reset.

Function
REQ-015 State: done register, BRANCHES bits; bit b set = branch b has completed its handshake for the pending upstream transfer.
REQ-016 o_valid[b] = i_valid & i_mask[b] & ~done[b]; purely combinational, no o_ready dependency (eager fork).
REQ-017 Branch b is complete this cycle when done[b] | ~i_mask[b] | (o_valid[b] & o_ready[b]).
REQ-018 i_ready = AND over all branches of complete; depends on i_valid only through the o_valid handshake term.
REQ-019 Upstream accept (i_valid & i_ready): done cleared to all-zero next cycle; o_count increments by 1.
REQ-020 No accept: done[b] set next cycle for every b with o_valid[b] & o_ready[b]; other bits hold.
REQ-021 Each branch sees exactly one handshake per upstream transfer with its mask bit set; never zero, never two.
REQ-022 Branches complete independently and in any order; a stalled branch does not block o_valid of others.
REQ-023 i_mask all-zero with i_valid high: i_ready high same cycle, no o_valid asserted, o_count still increments.
REQ-024 All selected branches ready in the same cycle: transfer completes in that cycle, zero latency, done stays zero.
REQ-025 Upstream SHALL hold i_data and i_mask stable while i_valid is high and not yet accepted; the block does not register payload.
REQ-026 o_busy = |done.
REQ-027 o_count wraps from 2^CNT_WIDTH-1 to 0 with no saturation or flag.
REQ-028 i_valid deasserting mid-transfer is a protocol violation; done holds its value until the next accept (not checked).
REQ-029 No combinational path from o_ready[b] to o_valid of any branch.

Reset
REQ-030 rstn low asynchronously forces done to zero and o_count to 0; o_busy low.
REQ-031 During reset o_valid and i_ready follow REQ-016/018 with done=0 (combinational); upstream SHALL hold i_valid low during reset.
REQ-032 Reset asserted mid-transfer discards partial completion; after release, every selected branch is offered the transfer again.
REQ-033 Reset release is synchronised externally; first state update is the first rising edge with rstn high.

Verification
REQ-034 BRANCHES=3, mask=3'b111, o_ready=3'b111, i_valid high 4 cycles -> 4 accepts, i_ready high every cycle, o_count=4, o_busy never high.
REQ-035 mask=3'b111, o_ready=3'b001 cycle 0, 3'b100 cycle 1, 3'b010 cycle 2 -> o_valid 111, 110, 010; i_ready high only cycle 2; o_busy high cycles 1-2; one handshake per branch.
REQ-036 mask=3'b101, o_ready=3'b010 held -> i_ready low, o_valid[1] low; then o_ready=3'b101 -> accept in that cycle, branch 1 never handshakes.
REQ-037 mask=3'b000, i_valid high 1 cycle -> i_ready high, o_valid=000, o_count +1.
REQ-038 CNT_WIDTH=2, 5 accepts -> o_count sequence 1,2,3,0,1.
REQ-039 mask=3'b111, branch 0 completes, rstn pulsed low mid-cycle -> done=0 immediately; after release o_valid=111 again, o_count unchanged from pre-transfer value.
